// File: rtl/vga_timing_gen_if.sv
// Pixel-side and DAC-side signals of the VGA timing generator.
// master = timing generator, slave = colour generator / DAC side.
interface vga_timing_gen_if #(
   parameter int RGB_W = 8
);
   logic [9:0]       x;
   logic [9:0]       y;
   logic             active;
   logic             line_start;
   logic             frame_start;
   logic [RGB_W-1:0] r_in;
   logic [RGB_W-1:0] g_in;
   logic [RGB_W-1:0] b_in;
   logic             hsync;
   logic             vsync;
   logic             sync_b;
   logic             blank_b;
   logic [RGB_W-1:0] r_out;
   logic [RGB_W-1:0] g_out;
   logic [RGB_W-1:0] b_out;

   modport master (
      output x, y, active, line_start, frame_start,
      output hsync, vsync, sync_b, blank_b, r_out, g_out, b_out,
      input  r_in, g_in, b_in
   );

   modport slave (
      input  x, y, active, line_start, frame_start,
      input  hsync, vsync, sync_b, blank_b, r_out, g_out, b_out,
      output r_in, g_in, b_in
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster counters plus a delayed sync/blank/RGB output stage; sync/blank reach
// the pins PIPE_LAT+1 pix_en ticks after their coordinate; everything holds while pix_en is low.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int PIPE_LAT  = 2,
   parameter int RGB_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   vga_timing_gen_if.master vif
);
   localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST    = 10'(HTOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(VTOTAL - 1);
   localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]         hcnt, vcnt;
   logic               line_start_q, frame_start_q;
   logic               act_raw, hs_raw, vs_raw;
   logic [2:0]         raw_vec, dly_out;
   logic               act_d, hs_d, vs_d;
   logic               hsync_q, vsync_q, blank_b_q;
   logic [RGB_W-1:0]   r_q, g_q, b_q;
   logic               hsync_n, vsync_n;

   wire h_wrap = (hcnt == H_LAST);
   wire v_wrap = (vcnt == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt          <= '0;
         vcnt          <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // Strobes mark the cycle after a tick that loads hcnt=0 (and vcnt=0).
         line_start_q  <= pix_en && h_wrap;
         frame_start_q <= pix_en && h_wrap && v_wrap;
         if (pix_en) begin
            if (h_wrap) begin
               hcnt <= '0;
               vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;
            end else begin
               hcnt <= hcnt + 10'd1;
            end
         end
      end
   end

   assign act_raw = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
   assign hs_raw  = (hcnt >= HS_START) && (hcnt < HS_END);
   assign vs_raw  = (vcnt >= VS_START) && (vcnt < VS_END);
   assign raw_vec = {act_raw, hs_raw, vs_raw};

   generate
      if (PIPE_LAT == 0) begin : g_no_dly
         assign dly_out = raw_vec;
      end else begin : g_dly
         logic [2:0] dly [PIPE_LAT];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE_LAT; i++) dly[i] <= 3'b000;
            end else if (pix_en) begin
               dly[0] <= raw_vec;
               for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
            end
         end
         assign dly_out = dly[PIPE_LAT-1];
      end
   endgenerate

   assign {act_d, hs_d, vs_d} = dly_out;

   // rgb_in arrives already aligned with act_d, so it is sampled on the same tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q   <= ~HSYNC_POL;
         vsync_q   <= ~VSYNC_POL;
         blank_b_q <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else if (pix_en) begin
         hsync_q   <= hs_d ? HSYNC_POL : ~HSYNC_POL;
         vsync_q   <= vs_d ? VSYNC_POL : ~VSYNC_POL;
         blank_b_q <= act_d;
         r_q       <= act_d ? vif.r_in : '0;
         g_q       <= act_d ? vif.g_in : '0;
         b_q       <= act_d ? vif.b_in : '0;
      end
   end

   assign hsync_n = HSYNC_POL ? ~hsync_q : hsync_q;
   assign vsync_n = VSYNC_POL ? ~vsync_q : vsync_q;

   assign vif.x           = hcnt;
   assign vif.y           = vcnt;
   assign vif.active      = act_raw;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.sync_b      = hsync_n & vsync_n;
   assign vif.blank_b     = blank_b_q;
   assign vif.r_out       = r_q;
   assign vif.g_out       = g_q;
   assign vif.b_out       = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (PIPE_LAT=2, active-low syncs) and a
// small-mode instance (PIPE_LAT=0, active-high syncs), both compared every cycle to a tick-count model.
module tb_vga_timing_gen;
   typedef struct {
      int ha, hfp, hsy, hbp;
      int va, vfp, vsy, vbp;
      bit hpol, vpol;
      int pl;
   } cfg_t;

   localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
   localparam cfg_t C1 = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};

   logic clk = 1'b0;
   logic reset0, reset1, pix_en0, pix_en1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.RGB_W(8)) vif0 ();
   vga_timing_gen_if #(.RGB_W(8)) vif1 ();

   vga_timing_gen #(.PIPE_LAT(2)) dut0 (
      .clk(clk), .reset(reset0), .pix_en(pix_en0), .vif(vif0.master)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_LAT(0), .RGB_W(8)
   ) dut1 (
      .clk(clk), .reset(reset1), .pix_en(pix_en1), .vif(vif1.master)
   );

   // Reference model: everything follows from the number of pix_en ticks since reset.
   function automatic int htot(cfg_t c);
      return c.ha + c.hfp + c.hsy + c.hbp;
   endfunction
   function automatic int vtot(cfg_t c);
      return c.va + c.vfp + c.vsy + c.vbp;
   endfunction
   function automatic int hof(cfg_t c, int k);
      return k % htot(c);
   endfunction
   function automatic int vof(cfg_t c, int k);
      return (k / htot(c)) % vtot(c);
   endfunction
   function automatic bit act_at(cfg_t c, int k);
      if (k < 0) return 1'b0;
      return (hof(c, k) < c.ha) && (vof(c, k) < c.va);
   endfunction
   function automatic bit hs_at(cfg_t c, int k);
      if (k < 0) return 1'b0;
      return (hof(c, k) >= c.ha + c.hfp) && (hof(c, k) < c.ha + c.hfp + c.hsy);
   endfunction
   function automatic bit vs_at(cfg_t c, int k);
      if (k < 0) return 1'b0;
      return (vof(c, k) >= c.va + c.vfp) && (vof(c, k) < c.va + c.vfp + c.vsy);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(
      input string nm, input cfg_t c, input int n, input bit lt, input logic [23:0] er,
      input logic [9:0] x, input logic [9:0] y, input logic active,
      input logic hsync, input logic vsync, input logic sync_b, input logic blank_b,
      input logic [23:0] rgb, input logic ls, input logic fs
   );
      bit hsa, vsa;
      int k;
      k   = n - 1 - c.pl;
      hsa = hs_at(c, k);
      vsa = vs_at(c, k);
      chk({nm, ".x"},           32'(x),       32'(hof(c, n)));
      chk({nm, ".y"},           32'(y),       32'(vof(c, n)));
      chk({nm, ".active"},      32'(active),  32'(act_at(c, n)));
      chk({nm, ".hsync"},       32'(hsync),   32'(hsa ? c.hpol : !c.hpol));
      chk({nm, ".vsync"},       32'(vsync),   32'(vsa ? c.vpol : !c.vpol));
      chk({nm, ".sync_b"},      32'(sync_b),  32'(!(hsa || vsa)));
      chk({nm, ".blank_b"},     32'(blank_b), 32'(act_at(c, k)));
      chk({nm, ".rgb_out"},     32'(rgb),     32'(er));
      chk({nm, ".line_start"},  32'(ls),      32'(lt && hof(c, n) == 0));
      chk({nm, ".frame_start"}, 32'(fs),      32'(lt && (n % (htot(c) * vtot(c))) == 0));
   endtask

   int          n0 = 0, n1 = 0;
   bit          lt0 = 1'b0, lt1 = 1'b0;
   logic [23:0] er0 = '0, er1 = '0;

   // One clk cycle: check the state left by the previous edge, then drive and advance the model.
   task automatic step(input bit pe0, input bit pe1, input bit r0, input bit r1, input bit do_chk);
      logic [7:0] rr, gg, bb;
      @(negedge clk);
      if (do_chk) begin
         check_dut("dut0", C0, n0, lt0, er0, vif0.x, vif0.y, vif0.active, vif0.hsync, vif0.vsync,
                   vif0.sync_b, vif0.blank_b, {vif0.r_out, vif0.g_out, vif0.b_out},
                   vif0.line_start, vif0.frame_start);
         check_dut("dut1", C1, n1, lt1, er1, vif1.x, vif1.y, vif1.active, vif1.hsync, vif1.vsync,
                   vif1.sync_b, vif1.blank_b, {vif1.r_out, vif1.g_out, vif1.b_out},
                   vif1.line_start, vif1.frame_start);
      end
      // r_in carries the low byte of the coordinate whose act_d is sampled on this tick.
      rr = (n0 - C0.pl >= 0) ? 8'(hof(C0, n0 - C0.pl)) : 8'($urandom);
      gg = 8'($urandom);
      bb = 8'($urandom);
      vif0.r_in = rr; vif0.g_in = gg; vif0.b_in = bb;
      pix_en0 = pe0; reset0 = r0;
      if (r0) begin
         n0 = 0; lt0 = 1'b0; er0 = '0;
      end else if (pe0) begin
         er0 = act_at(C0, n0 - C0.pl) ? {rr, gg, bb} : 24'h0;
         n0++; lt0 = 1'b1;
      end else begin
         lt0 = 1'b0;
      end
      rr = 8'(hof(C1, n1));
      gg = 8'($urandom);
      bb = 8'($urandom);
      vif1.r_in = rr; vif1.g_in = gg; vif1.b_in = bb;
      pix_en1 = pe1; reset1 = r1;
      if (r1) begin
         n1 = 0; lt1 = 1'b0; er1 = '0;
      end else if (pe1) begin
         er1 = act_at(C1, n1 - C1.pl) ? {rr, gg, bb} : 24'h0;
         n1++; lt1 = 1'b1;
      end else begin
         lt1 = 1'b0;
      end
   endtask

   initial begin
      int blank_cnt, fs_cnt;
      reset0 = 1'b1; reset1 = 1'b1; pix_en0 = 1'b0; pix_en1 = 1'b0;
      vif0.r_in = '0; vif0.g_in = '0; vif0.b_in = '0;
      vif1.r_in = '0; vif1.g_in = '0; vif1.b_in = '0;

      // Reset, with pix_en high to show reset wins.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // pix_en held high: full lines on dut0, many frames on dut1.
      for (int i = 0; i < 1700; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // One full small-mode frame: 32 visible ticks and exactly one frame_start.
      blank_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < 98; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
         blank_cnt += int'(vif1.blank_b);
         fs_cnt    += int'(vif1.frame_start);
      end
      chk("dut1.blank_per_frame", 32'(blank_cnt), 32'd32);
      chk("dut1.fs_per_frame",    32'(fs_cnt),    32'd1);

      // pix_en toggling 1,0 on dut0; random on dut1.
      for (int i = 0; i < 3400; i++)
         step(i[0] == 1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b1);

      // Sparse random pix_en on both.
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'b0, 1'b0, 1'b1);

      // Mid-frame reset for 3 cycles with pix_en low, then restart.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 1000; i++)
         step(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b1);

      // Mid-frame reset with pix_en high, then random stimulus.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1) == 1, 1'b1, 1'b0, 1'b0, 1'b1);

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
